video_timing_detect: RTL and testbench

Measures the incoming video raster carried by the decoded HDMI sync/DE stream and reports active size, total size and sync polarities once the timing is stable. Sits directly downstream of the HDMI receive path (deserializer, bit slipper, TMDS decoder) in the pixel clock domain. Consumes `hsync`, `vsync` and `de` only. Downstream scaler/frame-buffer logic uses `locked_out` and `sof_out` to start capturing frames.

---
 rtl/video_timing_detect.sv | 228 ++++++++++++++++++++++
 tb/tb_video_timing_detect.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_detect.sv
// Raster timing detector: measures active/total size and sync polarity of the decoded sync/DE stream.
// Latency: lock/unlock decided 2 clocks after the closing vsync active edge; sof_out 2 clocks after DE rise.
// Backpressure: none; free-running pixel-rate monitor, outputs are level status plus a one-cycle sof pulse.
module video_timing_detect #(
  parameter int CNT_W          = 12,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 16777215
) (
  input  logic             clk_1x_in,
  input  logic             reset_n_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic [CNT_W-1:0] active_width_out,
  output logic [CNT_W-1:0] active_height_out,
  output logic [CNT_W-1:0] total_width_out,
  output logic [CNT_W-1:0] total_height_out,
  output logic             hsync_pol_out,
  output logic             vsync_pol_out,
  output logic             locked_out,
  output logic             sof_out
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef struct packed {
    logic [CNT_W-1:0] aw;
    logic [CNT_W-1:0] ah;
    logic [CNT_W-1:0] tw;
    logic [CNT_W-1:0] th;
    logic             hpol;
    logic             vpol;
  } dims_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             hs_r_q, vs_r_q, de_r_q, hs_rr_q, vs_rr_q, de_rr_q;
  logic             hpol_q, hpol_d, vpol_q, vpol_d, saw_de_q, saw_de_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, decnt_q, decnt_d, faw_q, faw_d;
  logic [CNT_W-1:0] tw_q, tw_d, ah_q, ah_d, th_q, th_d;
  logic             faw_vld_q, faw_vld_d, incons_q, incons_d;
  logic [TO_W-1:0]  fcnt_q, fcnt_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       match_q, match_d, match_n;
  dims_t            cand_q, cand_d, out_q, out_d, meas;
  logic             locked_q, locked_d, sof_q, sof_d;
  logic             de_rise, de_fall, hs_edge, vs_edge, first_de, timeout;
  logic             meas_ok, incons_close;
  logic [CNT_W-1:0] aw_close;

  // Input register and second delayed copy for edge detection.
  always_ff @(posedge clk_1x_in) begin
    if (!reset_n_in) begin
      {hs_r_q, vs_r_q, de_r_q, hs_rr_q, vs_rr_q, de_rr_q} <= '0;
    end else begin
      {hs_r_q, vs_r_q, de_r_q}    <= {hsync_in, vsync_in, de_in};
      {hs_rr_q, vs_rr_q, de_rr_q} <= {hs_r_q, vs_r_q, de_r_q};
    end
  end

  // Edges normalized to the active sync level, plus the values that close the current frame.
  always_comb begin
    de_rise      = de_r_q & ~de_rr_q;
    de_fall      = ~de_r_q & de_rr_q;
    hs_edge      = ~(hs_r_q ^ hpol_q) & (hs_rr_q ^ hpol_q);
    vs_edge      = ~(vs_r_q ^ vpol_q) & (vs_rr_q ^ vpol_q);
    // A DE rise coinciding with the vsync edge opens the new frame.
    first_de     = de_rise & (vs_edge | (ah_q == '0));
    timeout      = (fcnt_q == TO_W'(TIMEOUT_CYCLES));
    // A DE fall on the closing cycle still belongs to the frame being closed.
    aw_close     = (de_fall & ~faw_vld_q) ? decnt_q : faw_q;
    incons_close = incons_q | (de_fall & faw_vld_q & (decnt_q != faw_q));
    meas         = {aw_close, ah_q, tw_q, th_q, hpol_q, vpol_q};
    meas_ok      = ~incons_close & (ah_q != '0);
  end

  // Polarity capture, per-line and per-frame counters, frame cycle counter.
  always_comb begin
    hpol_d    = hpol_q;
    vpol_d    = vpol_q;
    hcnt_d    = de_rise ? CNT_W'(1) : sat_inc(hcnt_q);
    decnt_d   = de_rise ? CNT_W'(1) : (de_r_q ? sat_inc(decnt_q) : decnt_q);
    faw_d     = faw_q;
    faw_vld_d = faw_vld_q;
    incons_d  = incons_q;
    tw_d      = tw_q;
    ah_d      = ah_q;
    th_d      = th_q;
    fcnt_d    = (vs_edge | timeout) ? '0 : fcnt_q + TO_W'(1);
    // Syncs are inactive during active video, so the level seen at DE rise is the inactive one.
    if (de_rise) begin
      hpol_d = ~hs_r_q;
      vpol_d = ~vs_r_q;
    end
    if (vs_edge) begin
      ah_d      = de_rise ? CNT_W'(1) : '0;
      th_d      = hs_edge ? CNT_W'(1) : '0;
      tw_d      = '0;
      faw_d     = '0;
      faw_vld_d = 1'b0;
      incons_d  = 1'b0;
    end else begin
      if (de_rise) begin
        ah_d = sat_inc(ah_q);
        // The first DE rise spans vertical blanking, so only line-to-line spacing is kept.
        if (ah_q != '0) tw_d = hcnt_q;
      end
      if (hs_edge) th_d = sat_inc(th_q);
      if (de_fall) begin
        if (!faw_vld_q) begin
          faw_d     = decnt_q;
          faw_vld_d = 1'b1;
        end else if (decnt_q != faw_q) begin
          incons_d = 1'b1;
        end
      end
    end
  end

  // Lock state machine: candidate tracking, lock/unlock, timeout and start-of-frame pulse.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    cand_d   = cand_q;
    out_d    = out_q;
    locked_d = locked_q;
    saw_de_d = saw_de_q | de_rise;
    sof_d    = first_de & locked_q;
    match_n  = (meas_ok && (meas == cand_q)) ?
               ((match_q == 4'hF) ? match_q : match_q + 4'd1) : 4'd1;
    if (timeout) begin
      state_d  = ST_SEARCH;
      locked_d = 1'b0;
      saw_de_d = 1'b0;
    end else if (vs_edge) begin
      case (state_q)
        ST_SEARCH: begin
          if (saw_de_q) begin
            state_d = ST_MEASURE;
            cand_d  = '0;
            match_d = '0;
          end
        end
        ST_MEASURE: begin
          cand_d  = meas;
          match_d = match_n;
          if (meas_ok && (match_n >= 4'(STABLE_FRAMES))) begin
            out_d    = meas;
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Outputs hold their last locked values while re-measuring.
          if (!(meas_ok && (meas == out_q))) begin
            locked_d = 1'b0;
            cand_d   = meas;
            match_d  = 4'd1;
            state_d  = ST_MEASURE;
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_1x_in) begin
    if (!reset_n_in) begin
      hpol_q    <= 1'b0;
      vpol_q    <= 1'b0;
      saw_de_q  <= 1'b0;
      hcnt_q    <= '0;
      decnt_q   <= '0;
      faw_q     <= '0;
      faw_vld_q <= 1'b0;
      incons_q  <= 1'b0;
      tw_q      <= '0;
      ah_q      <= '0;
      th_q      <= '0;
      fcnt_q    <= '0;
      state_q   <= ST_SEARCH;
      match_q   <= '0;
      cand_q    <= '0;
      out_q     <= '0;
      locked_q  <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      hpol_q    <= hpol_d;
      vpol_q    <= vpol_d;
      saw_de_q  <= saw_de_d;
      hcnt_q    <= hcnt_d;
      decnt_q   <= decnt_d;
      faw_q     <= faw_d;
      faw_vld_q <= faw_vld_d;
      incons_q  <= incons_d;
      tw_q      <= tw_d;
      ah_q      <= ah_d;
      th_q      <= th_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      match_q   <= match_d;
      cand_q    <= cand_d;
      out_q     <= out_d;
      locked_q  <= locked_d;
      sof_q     <= sof_d;
    end
  end

  assign active_width_out  = out_q.aw;
  assign active_height_out = out_q.ah;
  assign total_width_out   = out_q.tw;
  assign total_height_out  = out_q.th;
  assign hsync_pol_out     = out_q.hpol;
  assign vsync_pol_out     = out_q.vpol;
  assign locked_out        = locked_q;
  assign sof_out           = sof_q;

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect: 20x12 total / 16x8 active raster.
// Pixel (line 9, col 0) carries the vsync active edge; hsync active at cols 16..17.
// Outputs sampled 1ns after each rising edge, right after driving the next pixel.
`timescale 1ns/1ps
module tb_video_timing_detect;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [CNT_W-1:0] aw_o, ah_o, tw_o, th_o;
  logic             hpol_o, vpol_o, lock_o, sof_o;
  logic [4*CNT_W+3:0] snap;
  int               n_vec = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  video_timing_detect #(.CNT_W(CNT_W), .STABLE_FRAMES(2), .TIMEOUT_CYCLES(1000)) dut (
    .clk_1x_in        (clk),
    .reset_n_in       (rst_n),
    .hsync_in         (hs),
    .vsync_in         (vs),
    .de_in            (de),
    .active_width_out (aw_o),
    .active_height_out(ah_o),
    .total_width_out  (tw_o),
    .total_height_out (th_o),
    .hsync_pol_out    (hpol_o),
    .vsync_pol_out    (vpol_o),
    .locked_out       (lock_o),
    .sof_out          (sof_o)
  );

  task automatic drive(input logic h, input logic v, input logic d);
    @(posedge clk);
    #1;
    hs = h;
    vs = v;
    de = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // One full frame; rst_line >= 0 pulses reset at (rst_line,5) and snapshots outputs at (rst_line,6).
  task automatic run_frame(input int aw, input bit inv, input int rst_line,
                           output bit lk_pre, output bit lk_post,
                           output int sof_cnt, output int sof_at);
    sof_cnt = 0;
    sof_at  = -1;
    lk_pre  = 1'b0;
    lk_post = 1'b0;
    for (int l = 0; l < 12; l++) begin
      for (int c = 0; c < 20; c++) begin
        drive(logic'(((c >= 16) && (c < 18)) ^ inv), logic'(((l >= 9) && (l < 11)) ^ inv),
              logic'((l < 8) && (c < aw)));
        rst_n = !((l == rst_line) && (c == 5));
        if ((l == rst_line) && (c == 6))
          snap = {aw_o, ah_o, tw_o, th_o, hpol_o, vpol_o, lock_o, sof_o};
        if (sof_o) begin
          sof_cnt++;
          sof_at = l * 20 + c;
        end
        if ((l == 9) && (c == 1)) lk_pre = lock_o;
        if ((l == 9) && (c == 2)) lk_post = lock_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    snap = {aw_o, ah_o, tw_o, th_o, hpol_o, vpol_o, lock_o, sof_o};
    n_vec++; if (snap !== '0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", snap); end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b0, 1'b0);
    n_vec++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL reset_no_vsync_lock got %b want 0", lock_o); end
    n_vec++; if (sof_o !== 1'b0) begin n_bad++; $display("FAIL reset_no_vsync_sof got %b want 0", sof_o); end
  endtask

  task automatic test_basic_lock();
    bit pre, post;
    int sc, sa;
    do_reset();
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL basic_frame0_lock got %b want 0", post); end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL basic_frame1_lock got %b want 0", post); end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (pre !== 1'b0) begin n_bad++; $display("FAIL basic_lock_early got %b want 0", pre); end
    n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL basic_lock_at_2clk got %b want 1", post); end
    n_vec++; if (sc !== 0) begin n_bad++; $display("FAIL basic_sof_closing_frame got %0d want 0", sc); end
    n_vec++; if (aw_o !== 12'd16) begin n_bad++; $display("FAIL basic_aw got %0d want 16", aw_o); end
    n_vec++; if (ah_o !== 12'd8) begin n_bad++; $display("FAIL basic_ah got %0d want 8", ah_o); end
    n_vec++; if (tw_o !== 12'd20) begin n_bad++; $display("FAIL basic_tw got %0d want 20", tw_o); end
    n_vec++; if (th_o !== 12'd12) begin n_bad++; $display("FAIL basic_th got %0d want 12", th_o); end
    n_vec++; if ({hpol_o, vpol_o} !== 2'b11) begin n_bad++; $display("FAIL basic_pol got %b%b want 11", hpol_o, vpol_o); end
    for (int f = 0; f < 2; f++) begin
      run_frame(16, 1'b0, -1, pre, post, sc, sa);
      n_vec++; if (sc !== 1) begin n_bad++; $display("FAIL basic_sof_count frame %0d got %0d want 1", f, sc); end
      n_vec++; if (sa !== 2) begin n_bad++; $display("FAIL basic_sof_pos frame %0d got %0d want 2", f, sa); end
      n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL basic_stay_locked frame %0d got %b want 1", f, post); end
    end
  endtask

  task automatic test_timing_change();
    bit pre, post;
    int sc, sa;
    run_frame(14, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (pre !== 1'b1) begin n_bad++; $display("FAIL change_lock_before got %b want 1", pre); end
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL change_unlock got %b want 0", post); end
    n_vec++; if (sc !== 1) begin n_bad++; $display("FAIL change_sof_while_locked got %0d want 1", sc); end
    n_vec++; if (aw_o !== 12'd16) begin n_bad++; $display("FAIL change_aw_held got %0d want 16", aw_o); end
    run_frame(14, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL change_relock got %b want 1", post); end
    n_vec++; if (sc !== 0) begin n_bad++; $display("FAIL change_sof_unlocked got %0d want 0", sc); end
    n_vec++; if (aw_o !== 12'd14) begin n_bad++; $display("FAIL change_aw got %0d want 14", aw_o); end
    n_vec++; if (ah_o !== 12'd8) begin n_bad++; $display("FAIL change_ah got %0d want 8", ah_o); end
    n_vec++; if (tw_o !== 12'd20) begin n_bad++; $display("FAIL change_tw got %0d want 20", tw_o); end
    n_vec++; if (th_o !== 12'd12) begin n_bad++; $display("FAIL change_th got %0d want 12", th_o); end
  endtask

  task automatic test_active_low();
    bit pre, post;
    int sc, sa;
    do_reset();
    run_frame(16, 1'b1, -1, pre, post, sc, sa);
    run_frame(16, 1'b1, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL low_frame1_lock got %b want 0", post); end
    run_frame(16, 1'b1, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL low_lock got %b want 1", post); end
    n_vec++; if ({aw_o, ah_o, tw_o, th_o} !== {12'd16, 12'd8, 12'd20, 12'd12}) begin
      n_bad++; $display("FAIL low_dims got %0d/%0d/%0d/%0d want 16/8/20/12", aw_o, ah_o, tw_o, th_o);
    end
    n_vec++; if ({hpol_o, vpol_o} !== 2'b00) begin n_bad++; $display("FAIL low_pol got %b%b want 00", hpol_o, vpol_o); end
  endtask

  task automatic test_timeout();
    bit pre, post;
    int sc, sa;
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL timeout_prelock got %b want 1", post); end
    // Index 0 is the pixel carrying the last vsync edge; the frame ended at index 59.
    for (int k = 60; k < 1010; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (k == 1002) begin
        n_vec++; if (lock_o !== 1'b1) begin n_bad++; $display("FAIL timeout_early got %b want 1", lock_o); end
      end
      if (k == 1003) begin
        n_vec++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL timeout_drop got %b want 0", lock_o); end
      end
    end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL timeout_restart_f0 got %b want 0", post); end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL timeout_restart_f1 got %b want 0", post); end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL timeout_relock got %b want 1", post); end
  endtask

  task automatic test_reset_midlock();
    bit pre, post;
    int sc, sa;
    run_frame(16, 1'b0, 3, pre, post, sc, sa);
    n_vec++; if (snap !== '0) begin n_bad++; $display("FAIL midlock_reset_outputs got %h want 0", snap); end
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL midlock_f0 got %b want 0", post); end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b0) begin n_bad++; $display("FAIL midlock_f1 got %b want 0", post); end
    run_frame(16, 1'b0, -1, pre, post, sc, sa);
    n_vec++; if (post !== 1'b1) begin n_bad++; $display("FAIL midlock_relock got %b want 1", post); end
    n_vec++; if ({aw_o, ah_o, tw_o, th_o, hpol_o, vpol_o} !== {12'd16, 12'd8, 12'd20, 12'd12, 2'b11}) begin
      n_bad++; $display("FAIL midlock_dims got %0d/%0d/%0d/%0d pol %b%b want 16/8/20/12 pol 11",
                        aw_o, ah_o, tw_o, th_o, hpol_o, vpol_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_timing_change();
    test_active_low();
    test_timeout();
    test_reset_midlock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not complete, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
